// File: rtl/sap_ctrl_pkg.sv
// rtl/sap_ctrl_pkg.sv - opcodes, T-state encodings and control-bit indices for the SAP sequencer
package sap_ctrl_pkg;

    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        T5   = 3'd5,
        HALT = 3'd7
    } t_state_e;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_JMP = 4'h3;
    localparam logic [3:0] OP_JC  = 4'h4;
    localparam logic [3:0] OP_JZ  = 4'h5;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int CTL_W  = 13;
    localparam int CTL_CP = 12;
    localparam int CTL_EP = 11;
    localparam int CTL_LP = 10;
    localparam int CTL_LM = 9;
    localparam int CTL_CE = 8;
    localparam int CTL_LI = 7;
    localparam int CTL_EI = 6;
    localparam int CTL_LA = 5;
    localparam int CTL_EA = 4;
    localparam int CTL_LB = 3;
    localparam int CTL_SU = 2;
    localparam int CTL_EU = 1;
    localparam int CTL_LO = 0;

endpackage

// File: rtl/sap_ring_counter.sv
// rtl/sap_ring_counter.sv - T-state ring with enable hold, wrap, halt entry and early retire
module sap_ring_counter
    import sap_ctrl_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     en,
    input  logic     halt_req,
    input  logic     retire,
    output t_state_e state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= T0;
        end else if (en) begin
            if (state == HALT) begin
                state <= HALT;
            end else if (halt_req) begin
                state <= HALT;
            end else if (retire || state == T5) begin
                state <= T0;
            end else begin
                state <= t_state_e'(state + 3'd1);
            end
        end
    end

endmodule

// File: rtl/sap_control_sequencer.sv
// rtl/sap_control_sequencer.sv - SAP control sequencer: T-state ring plus opcode/flag decode
// Optional macro: SEQ_EARLY_RETIRE_EN (return to T0 after the last active execute step)
module sap_control_sequencer
    import sap_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] opcode,
    input  logic       flag_c,
    input  logic       flag_z,
    output logic       cp,
    output logic       ep,
    output logic       lp,
    output logic       lm,
    output logic       ce,
    output logic       li,
    output logic       ei,
    output logic       la,
    output logic       ea,
    output logic       lb,
    output logic       su,
    output logic       eu,
    output logic       lo,
    output logic       hlt,
    output logic [2:0] t_state
);

    t_state_e          state;
    logic              halt_req;
    logic              retire;
    logic [CTL_W-1:0]  ctl;

    assign halt_req = (state == T3) && (opcode == OP_HLT);

`ifdef SEQ_EARLY_RETIRE_EN
    // LDA retires after T4; every other single-step opcode (and NOP) after T3.
    always_comb begin
        retire = 1'b0;
        if (state == T3) begin
            retire = !(opcode == OP_LDA || opcode == OP_ADD ||
                       opcode == OP_SUB || opcode == OP_HLT);
        end else if (state == T4) begin
            retire = (opcode == OP_LDA);
        end
    end
`else
    assign retire = 1'b0;
`endif

    sap_ring_counter u_ring (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .halt_req (halt_req),
        .retire   (retire),
        .state    (state)
    );

    // Gating with rst_n keeps the T0 fetch controls quiet while reset is held.
    always_comb begin
        ctl = '0;
        if (rst_n && en) begin
            case (state)
                T0: begin ctl[CTL_EP] = 1'b1; ctl[CTL_LM] = 1'b1; end
                T1: ctl[CTL_CP] = 1'b1;
                T2: begin ctl[CTL_CE] = 1'b1; ctl[CTL_LI] = 1'b1; end
                T3: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ctl[CTL_EI] = 1'b1; ctl[CTL_LM] = 1'b1;
                        end
                        OP_JMP: begin ctl[CTL_EI] = 1'b1; ctl[CTL_LP] = 1'b1; end
                        OP_JC:  begin ctl[CTL_EI] = 1'b1; ctl[CTL_LP] = flag_c; end
                        OP_JZ:  begin ctl[CTL_EI] = 1'b1; ctl[CTL_LP] = flag_z; end
                        OP_OUT: begin ctl[CTL_EA] = 1'b1; ctl[CTL_LO] = 1'b1; end
                        default: ;
                    endcase
                end
                T4: begin
                    case (opcode)
                        OP_LDA: begin ctl[CTL_CE] = 1'b1; ctl[CTL_LA] = 1'b1; end
                        OP_ADD, OP_SUB: begin
                            ctl[CTL_CE] = 1'b1; ctl[CTL_LB] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        ctl[CTL_EU] = 1'b1;
                        ctl[CTL_LA] = 1'b1;
                        ctl[CTL_SU] = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign cp = ctl[CTL_CP];
    assign ep = ctl[CTL_EP];
    assign lp = ctl[CTL_LP];
    assign lm = ctl[CTL_LM];
    assign ce = ctl[CTL_CE];
    assign li = ctl[CTL_LI];
    assign ei = ctl[CTL_EI];
    assign la = ctl[CTL_LA];
    assign ea = ctl[CTL_EA];
    assign lb = ctl[CTL_LB];
    assign su = ctl[CTL_SU];
    assign eu = ctl[CTL_EU];
    assign lo = ctl[CTL_LO];

    assign hlt     = (state == HALT);
    assign t_state = state;

endmodule
